// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader: FSM state encoding,
// skid buffer size and the occupancy-counter width helper.
package fifo_burst_reader_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   // Three entries cover the one-cycle FIFO read latency plus one beat of
   // slack, enough for one beat per clock with out_ready held high.
   localparam int SKID_DEPTH = 3;

   // Occupancy counters must represent 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_burst_reader_skid.sv
// In-order 3-entry register FIFO holding {last, data} beats between the
// FIFO read port and the output stream. Entry 0 is always the head, so
// the head only changes on a pop or on a push into an empty buffer.
module fifo_reader_skid
   import fifo_burst_reader_pkg::*;
#(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   occ,
   output logic         valid
);

   logic [W-1:0] mem [SKID_DEPTH];
   logic         do_push;
   logic         do_pop;
   logic [1:0]   wr_idx;

   assign valid   = (occ != 2'd0);
   assign do_pop  = pop && valid;
   // The reader never over-issues, but a push into a full buffer is
   // still dropped rather than corrupting the head.
   assign do_push = push && ((occ != 2'(SKID_DEPTH)) || do_pop);
   // Write slot is computed after the shift caused by a same-cycle pop.
   assign wr_idx  = occ - {1'b0, do_pop};
   assign head    = mem[0];

   // Shift-down storage with occupancy tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
         occ <= 2'd0;
      end else begin
         if (do_pop) begin
            for (int i = 0; i < SKID_DEPTH - 1; i++) mem[i] <= mem[i+1];
         end
         // Later assignment wins over the shift for the written slot.
         if (do_push) begin
            case (wr_idx)
               2'd0:    mem[0] <= push_data;
               2'd1:    mem[1] <= push_data;
               default: mem[2] <= push_data;
            endcase
         end
         occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side master for the elastic FIFOs. Waits for a full burst (or a
// flush request with a short tail), drains exactly that many words with
// one-cycle read latency and presents them as a valid/ready stream with
// out_last on the final beat of each burst.
module fifo_burst_reader
   import fifo_burst_reader_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 32,
   parameter int CNT_W = cnt_width(DEPTH),
   parameter int BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [CNT_W-1:0] fifo_count,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_rd_en,
   input  logic             flush,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy
);

   localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

   state_t           state;
   logic [CNT_W-1:0] beats_left;
   logic [CNT_W-1:0] total;
   logic [CNT_W-1:0] cap_cnt;
   logic             inflight;
   logic [1:0]       skid_occ;
   logic [WIDTH:0]   skid_head;
   logic             cap_last;
   logic             xfer_last;

   // Reads only go out when the skid buffer can absorb every word already
   // requested plus this one; out_ready is deliberately not in this path.
   assign fifo_rd_en = (state != S_IDLE) && (beats_left != '0) && !fifo_empty &&
                       (({1'b0, skid_occ} + {2'b00, inflight}) <= 3'(SKID_DEPTH - 1));

   // The word arriving now is beat number cap_cnt+1 of the burst.
   assign cap_last  = ((cap_cnt + CNT_W'(1)) == total);
   assign xfer_last = out_valid && out_ready && out_last;
   assign busy      = (state != S_IDLE);

   assign out_data  = skid_head[WIDTH-1:0];
   assign out_last  = skid_head[WIDTH];

   // Burst FSM: burst sizing in IDLE, read/capture counting while active
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         beats_left <= '0;
         total      <= '0;
         cap_cnt    <= '0;
         inflight   <= 1'b0;
      end else begin
         inflight <= fifo_rd_en;
         case (state)
            S_IDLE: begin
               // No reads happen in IDLE, so fifo_count is exact here and
               // a full burst takes priority over a flush tail.
               if (fifo_count >= BURST_C) begin
                  state      <= S_BURST;
                  beats_left <= BURST_C;
                  total      <= BURST_C;
                  cap_cnt    <= '0;
               end else if (flush && (fifo_count != '0)) begin
                  state      <= S_FLUSH;
                  beats_left <= fifo_count;
                  total      <= fifo_count;
                  cap_cnt    <= '0;
               end
            end
            default: begin
               if (fifo_rd_en) beats_left <= beats_left - CNT_W'(1);
               if (inflight)   cap_cnt    <= cap_cnt + CNT_W'(1);
               if (xfer_last)  state      <= S_IDLE;
            end
         endcase
      end
   end

   fifo_reader_skid #(
      .W (WIDTH + 1)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data ({cap_last, fifo_data}),
      .pop       (out_ready),
      .head      (skid_head),
      .occ       (skid_occ),
      .valid     (out_valid)
   );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a queue-based FIFO environment,
// a burst-grouping reference model and a negedge monitor.
module tb_fifo_burst_reader;

   localparam int WIDTH = 8;
   localparam int DEPTH = 32;
   localparam int BURST = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic             last;
      logic [WIDTH-1:0] data;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             fifo_empty = 1'b1;
   logic [CNT_W-1:0] fifo_count = '0;
   logic [WIDTH-1:0] fifo_data = '0;
   logic             fifo_rd_en;
   logic             flush = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic             out_last;
   logic             busy;

   logic             wr_en = 1'b0;
   logic [WIDTH-1:0] wr_data = '0;
   int               rdy_mode = 0;

   int total = 0;
   int bad   = 0;

   logic [WIDTH-1:0] mem_q[$];
   logic [WIDTH-1:0] unassigned_q[$];
   beat_t            exp_q[$];
   bit               active = 1'b0;
   int               outstanding = 0;
   bit               prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;
   logic             prev_last = 1'b0;
   int               cyc_n = 0;
   int               rd_hist[$];
   int               xf_hist[$];

   always #5 clk = ~clk;

   fifo_burst_reader #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W),
      .BURST (BURST)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .fifo_count (fifo_count),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .flush      (flush),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Assign the next n written words to a burst; the n-th carries last.
   task automatic take(input int n);
      beat_t b;
      chk("model_words_avail", 32'(unassigned_q.size() >= n), 32'd1);
      for (int i = 0; i < n; i++) begin
         if (unassigned_q.size() != 0) begin
            b.data = unassigned_q.pop_front();
            b.last = (i == n - 1);
            exp_q.push_back(b);
         end
      end
      active = 1'b1;
   endtask

   // FIFO environment: 1-cycle read latency, count/empty registered
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q.delete();
         fifo_count <= '0;
         fifo_empty <= 1'b1;
         fifo_data  <= '0;
      end else begin
         if (fifo_rd_en && mem_q.size() != 0) fifo_data <= mem_q.pop_front();
         if (wr_en && mem_q.size() < DEPTH) begin
            mem_q.push_back(wr_data);
            unassigned_q.push_back(wr_data);
         end
         fifo_count <= CNT_W'(mem_q.size());
         fifo_empty <= (mem_q.size() == 0);
      end
   end

   // Monitor + reference model, sampled mid-cycle
   always @(negedge clk) begin
      bit    xfer;
      beat_t e;
      int    n;
      cyc_n++;
      if (!rst) begin
         xfer = out_valid && out_ready;
         chk("busy", 32'(busy), 32'(active));
         if (!active) chk("rd_in_idle", 32'(fifo_rd_en), 32'd0);
         if (prev_stall) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(prev_data));
            chk("hold_last", 32'(out_last), 32'(prev_last));
         end
         if (fifo_rd_en && !fifo_empty) begin
            outstanding++;
            rd_hist.push_back(cyc_n);
         end
         if (xfer) begin
            xf_hist.push_back(cyc_n);
            outstanding--;
            chk("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("out_data", 32'(out_data), 32'(e.data));
               chk("out_last", 32'(out_last), 32'(e.last));
            end
         end
         chk("outstanding_le3", 32'(outstanding <= 3), 32'd1);
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         if (active) begin
            if (xfer && out_last) active = 1'b0;
         end else begin
            n = int'(fifo_count);
            if (n >= BURST)              take(BURST);
            else if (flush && n != 0)    take(n);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      if (rdy_mode == 1)      out_ready = ~out_ready;
      else if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic wr_n(input logic [WIDTH-1:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         wr_en   = 1'b1;
         wr_data = base + WIDTH'(i);
         cyc();
      end
      wr_en = 1'b0;
   endtask

   task automatic wait_done(input int maxc, input string nm);
      int k = 0;
      cyc();
      cyc();
      while ((active || busy || exp_q.size() != 0 || unassigned_q.size() >= BURST ||
              (flush && unassigned_q.size() != 0)) && k < maxc) begin
         cyc();
         k++;
      end
      chk({nm, "_timeout"}, 32'(k < maxc), 32'd1);
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_valid"}, 32'(out_valid), 32'd0);
      chk({nm, "_last"},  32'(out_last),  32'd0);
      chk({nm, "_data"},  32'(out_data),  32'd0);
      chk({nm, "_busy"},  32'(busy),      32'd0);
      chk({nm, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t want < 200000", $time);
      $fatal(1);
   end

   initial begin
      logic [WIDTH-1:0] seq;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outs("reset");
      rst = 1'b0;

      // Basic burst of four
      rd_hist.delete(); xf_hist.delete();
      wr_n(8'hA0, 4);
      wait_done(40, "t1");
      chk("t1_reads", 32'(rd_hist.size()), 32'd4);
      if (rd_hist.size() == 4) chk("t1_rd_consec", 32'(rd_hist[3] - rd_hist[0]), 32'd3);
      chk("t1_beats", 32'(xf_hist.size()), 32'd4);
      if (xf_hist.size() == 4) chk("t1_xf_consec", 32'(xf_hist[3] - xf_hist[0]), 32'd3);

      // Short tail waits for flush
      rd_hist.delete(); xf_hist.delete();
      wr_n(8'hB0, 3);
      repeat (8) cyc();
      chk("t2_idle_busy", 32'(busy), 32'd0);
      chk("t2_no_reads", 32'(rd_hist.size()), 32'd0);
      flush = 1'b1;
      wait_done(40, "t2");
      flush = 1'b0;
      chk("t2_count", 32'(fifo_count), 32'd0);
      chk("t2_beats", 32'(xf_hist.size()), 32'd3);

      // Toggling out_ready across two bursts
      xf_hist.delete();
      rdy_mode = 1;
      wr_n(8'hC0, 8);
      wait_done(80, "t3");
      rdy_mode = 0;
      out_ready = 1'b1;
      chk("t3_beats", 32'(xf_hist.size()), 32'd8);

      // Back-pressure caps outstanding reads at three
      out_ready = 1'b0;
      wr_n(8'hD0, 4);
      rd_hist.delete();
      repeat (10) cyc();
      chk("t4_reads_stalled", 32'(rd_hist.size()), 32'd3);
      chk("t4_busy", 32'(busy), 32'd1);
      out_ready = 1'b1;
      wait_done(40, "t4");

      // Asynchronous reset two beats into a burst, then a clean refill
      xf_hist.delete();
      wr_n(8'hE0, 4);
      for (int k = 0; k < 20 && xf_hist.size() < 2; k++) cyc();
      chk("t5_two_beats", 32'(xf_hist.size() >= 2), 32'd1);
      #3;
      rst = 1'b1;
      #1;
      chk_reset_outs("t5_async_rst");
      exp_q.delete(); unassigned_q.delete();
      active = 1'b0; outstanding = 0; prev_stall = 1'b0;
      repeat (2) cyc();
      rst = 1'b0;
      xf_hist.delete();
      wr_n(8'hF0, 4);
      wait_done(40, "t5");
      chk("t5_refill_beats", 32'(xf_hist.size()), 32'd4);

      // Writes continue during a burst: 4 + 4, remainder needs flush
      xf_hist.delete();
      wr_n(8'h10, 9);
      wait_done(60, "t6");
      chk("t6_beats", 32'(xf_hist.size()), 32'd8);
      chk("t6_left", 32'(fifo_count), 32'd1);
      flush = 1'b1;
      wait_done(20, "t6_tail");
      flush = 1'b0;
      chk("t6_all_beats", 32'(xf_hist.size()), 32'd9);

      // Random writes, back-pressure and flush
      seq = 8'h40;
      rdy_mode = 2;
      for (int k = 0; k < 400; k++) begin
         wr_en   = ($urandom_range(0, 99) < 45) && (int'(fifo_count) < DEPTH - 2);
         wr_data = seq;
         if (wr_en) seq = seq + 8'd1;
         flush   = ($urandom_range(0, 99) < 5);
         cyc();
      end
      wr_en = 1'b0;
      rdy_mode = 0;
      out_ready = 1'b1;
      flush = 1'b1;
      wait_done(300, "t7");
      flush = 1'b0;
      chk("t7_unassigned", 32'(unassigned_q.size()), 32'd0);
      chk("t7_count", 32'(fifo_count), 32'd0);
      chk("t7_busy", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
